gsim_mem_responder: RTL and testbench
=====================================

# gsim_mem_responder

Responder end of the GSIM matrix-memory read interface. Accepts 10-bit read requests from the GSIM core (`rreq`/`rrdy`), fetches 256-bit words (one 16-element row block or b-vector block) from a single-port backing SRAM, and returns them with a fixed-latency `dout_vld` pulse. Also owns the preload path that fills the SRAM with matrix sets before `i_module_en`. Sits between the GSIM core and the matrix SRAM macro.

## Interface
- `RD_LAT`, 1: SRAM read latency in cycles; legal range 1..4.
- `DEPTH`, 1024: number of valid words; addresses `>= DEPTH` are out of range.
- `MAX_OUT`, `RD_LAT+1`: maximum number of reads in flight.
- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_mem_rreq`  in  1  read request from the core.
- `i_mem_addr`  in  10  read word address.
- `o_mem_rrdy`  out  1  request accepted this cycle when `rreq & rrdy`.
- `o_mem_dout`  out  256  read data.
- `o_mem_dout_vld`  out  1  one-cycle pulse per returned word.
- `o_mem_oob`  out  1  pulses with `dout_vld` when that word's address was out of range.
- `i_ld_wen`  in  1  preload write strobe.
- `i_ld_addr`  in  10  preload address.
- `i_ld_data`  in  256  preload data.
- `i_ld_done`  in  1  preload finished; enter serve mode.
- `o_ld_rdy`  out  1  preload write accepted when `ld_wen & ld_rdy`.
- `o_sram_cen`, `o_sram_wen`  out  1 each  active-high SRAM enable and write.
- `o_sram_addr`  out  10; `o_sram_wdata`  out  256; `i_sram_rdata`  in  256.

## Operation
- FSM states:
  - S_IDLE: `ld_rdy=1`, `rrdy=0`.
  - S_LOAD: `ld_rdy=1`, `rrdy=0`.
  - S_SERVE: `rrdy=(outstanding<MAX_OUT)`, `ld_rdy=(outstanding==0)`.
- Transitions:
  - IDLE→LOAD on an accepted `ld_wen`.
  - IDLE→SERVE or LOAD→SERVE on `i_ld_done`.
  - SERVE→LOAD on an accepted `ld_wen`.
  - `ld_done` and an accepted `ld_wen` in the same cycle: perform the write, then go to SERVE.
- Accepted preload write drives `cen=1`, `wen=1`, `addr=ld_addr`, `wdata=ld_data` in the same cycle (combinational). When `ld_wen` is high, `rrdy` is forced 0 in that cycle, so a write wins over a read.
- Accepted in-range read drives `cen=1`, `wen=0`, `addr=i_mem_addr` in the same cycle.
- Out-of-range read: SRAM not enabled. A zero word is returned with `oob=1` at the normal latency.
- Valid/oob shift pipeline of length `RD_LAT`. The output register captures `i_sram_rdata` (or 0 for oob) when the pipeline tail is set.
- Outstanding counter (width clog2(MAX_OUT+1)):
  - +1 on accept, −1 on `dout_vld`; unchanged when both happen in one cycle.
  - Never exceeds `MAX_OUT`.
- Returns are in request order. There is no backpressure on the return path.
- `o_mem_dout` holds its last value between pulses.

## Timing
- Read accepted at cycle t → `o_mem_dout_vld` at t+RD_LAT+1. With `MAX_OUT=RD_LAT+1`, back-to-back accepts sustain one word per cycle.
- `rrdy` is combinational from state, counter and `ld_wen`. It may change in the same cycle the counter changes.
- Reset values:
  - state S_IDLE; counter 0; pipeline cleared.
  - `o_mem_dout=0`, `o_mem_dout_vld=0`, `o_mem_oob=0`, `o_mem_rrdy=0`, `o_ld_rdy=1`.
  - SRAM strobes 0.
- Reset mid-operation drops all in-flight reads. No `dout_vld` occurs after the reset cycle.
- `rreq` while `rrdy=0` is ignored and is not queued. The core must hold `rreq`/`addr` until accepted.

## Structure
- Shared package (`define.v` style): state encodings `S_IDLE`/`S_LOAD`/`S_SERVE`, `MEM_AW=10`, `MEM_DW=256`.
- One natural sub-module: `gsim_rd_pipe`, the `RD_LAT`-deep valid/oob shift register plus the output data register.
- FSM, arbitration and the outstanding counter stay in the top.

## Test plan
- Reset then preload: addrs 0..3 written with 0xA0..0xA3 patterns, `ld_done` → state SERVE, `rrdy=1`.
- Single read of addr 2 at t (RD_LAT=2) → `dout_vld` only at t+3, `dout`=0xA2 pattern, `oob=0`.
- Back-to-back reads of addrs 0,1,2,3 with `rreq` held high → four consecutive `dout_vld` pulses with data in order; `rrdy` never drops.
- `MAX_OUT=1` with `rreq` held → `rrdy` low until each return. One word every RD_LAT+1 cycles; counter peaks at 1.
- Read of addr 1023 with `DEPTH=512` → zero data with `oob=1` at t+RD_LAT+1; `o_sram_cen` stays low that cycle.
- `i_reset` asserted with 2 reads in flight → no `dout_vld` afterwards; `rrdy=0`, `ld_rdy=1`, counter 0.

Source files
------------

// File: rtl/gsim_mem_responder_pkg.sv
// Shared definitions for the GSIM matrix-memory responder: bus widths,
// FSM state encodings and the per-read tag carried down the read pipeline.
package gsim_mem_responder_pkg;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned MEM_DW = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SERVE = 2'd2
  } state_e;

  // One entry per accepted read travelling alongside the SRAM access
  typedef struct packed {
    logic vld;
    logic oob;
  } rd_tag_t;

endpackage

// File: rtl/gsim_rd_pipe.sv
// RD_LAT-deep valid/oob shift register plus the returned-data register;
// out-of-range reads return a zero word.
module gsim_rd_pipe
  import gsim_mem_responder_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  rd_tag_t           i_tag,
  input  logic [MEM_DW-1:0] i_sram_rdata,
  output logic [MEM_DW-1:0] o_dout,
  output logic              o_dout_vld,
  output logic              o_oob
);

  rd_tag_t [RD_LAT-1:0] pipe;
  rd_tag_t              tail;

  assign tail = pipe[RD_LAT-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pipe       <= '0;
      o_dout     <= '0;
      o_dout_vld <= 1'b0;
      o_oob      <= 1'b0;
    end else begin
      pipe[0] <= i_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      o_dout_vld <= tail.vld;
      o_oob      <= tail.vld & tail.oob;
      // data holds between returns
      if (tail.vld) begin
        o_dout <= tail.oob ? '0 : i_sram_rdata;
      end
    end
  end

endmodule

// File: rtl/gsim_mem_responder.sv
// Responder for the GSIM matrix-memory read port: preload FSM, read/write
// arbitration onto the single-port SRAM and in-flight read accounting.
module gsim_mem_responder
  import gsim_mem_responder_pkg::*;
#(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned MAX_OUT = RD_LAT + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_rreq,
  input  logic [MEM_AW-1:0] i_mem_addr,
  output logic              o_mem_rrdy,
  output logic [MEM_DW-1:0] o_mem_dout,
  output logic              o_mem_dout_vld,
  output logic              o_mem_oob,
  input  logic              i_ld_wen,
  input  logic [MEM_AW-1:0] i_ld_addr,
  input  logic [MEM_DW-1:0] i_ld_data,
  input  logic              i_ld_done,
  output logic              o_ld_rdy,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [MEM_AW-1:0] o_sram_addr,
  output logic [MEM_DW-1:0] o_sram_wdata,
  input  logic [MEM_DW-1:0] i_sram_rdata
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] outstanding;
  logic          ld_acc;
  logic          rd_acc;
  logic          rd_oob;
  logic          slot_free;
  rd_tag_t       rd_tag;

  assign rd_oob = 32'(i_mem_addr) >= DEPTH;
  // a word returning this cycle frees its slot, so full-rate reads never bubble
  assign slot_free = (outstanding < CW'(MAX_OUT)) || o_mem_dout_vld;
  assign rd_tag    = '{vld: rd_acc, oob: rd_oob};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    o_mem_rrdy   = 1'b0;
    o_ld_rdy     = 1'b1;
    ld_acc       = 1'b0;
    rd_acc       = 1'b0;
    o_sram_cen   = 1'b0;
    o_sram_wen   = 1'b0;
    o_sram_addr  = i_mem_addr;
    o_sram_wdata = i_ld_data;
    if (!i_reset) begin
      case (state)
        S_SERVE: begin
          o_mem_rrdy = slot_free && !i_ld_wen;
          o_ld_rdy   = (outstanding == '0);
        end
        default: begin
          o_mem_rrdy = 1'b0;
          o_ld_rdy   = 1'b1;
        end
      endcase
      ld_acc = i_ld_wen && o_ld_rdy;
      rd_acc = i_mem_rreq && o_mem_rrdy;
      if (ld_acc) begin
        o_sram_cen  = 1'b1;
        o_sram_wen  = 1'b1;
        o_sram_addr = i_ld_addr;
      end else if (rd_acc && !rd_oob) begin
        o_sram_cen = 1'b1;
      end
      if (i_ld_done) begin
        state_nxt = S_SERVE;
      end else if (ld_acc) begin
        state_nxt = S_LOAD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      outstanding <= '0;
    end else if (rd_acc && !o_mem_dout_vld) begin
      outstanding <= outstanding + CW'(1);
    end else if (!rd_acc && o_mem_dout_vld) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  gsim_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tag        (rd_tag),
    .i_sram_rdata (i_sram_rdata),
    .o_dout       (o_mem_dout),
    .o_dout_vld   (o_mem_dout_vld),
    .o_oob        (o_mem_oob)
  );

endmodule

// File: tb/tb_gsim_mem_responder.sv
// Scoreboard bench for gsim_mem_responder: one instance at full rate with a
// 512-word range, one limited to a single read in flight.
module tb_gsim_mem_responder;
  import gsim_mem_responder_pkg::*;

  localparam int unsigned LAT     = 2;
  localparam int unsigned DEPTH_A = 512;
  localparam int unsigned DEPTH_B = 1024;
  localparam logic [255:0] JUNK   = {8{32'hDEADBEEF}};

  typedef struct {
    logic [255:0] data;
    logic         oob;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          i_reset = 1'b1;
  logic          ld_wen = 1'b0, ld_done = 1'b0;
  logic [9:0]    ld_addr = '0;
  logic [255:0]  ld_data = '0;
  logic          rreq_a = 1'b0, rreq_b = 1'b0;
  logic [9:0]    addr_a = '0, addr_b = '0;

  logic          a_rrdy, a_vld, a_oob, a_ldrdy, a_cen, a_wen;
  logic [9:0]    a_saddr;
  logic [255:0]  a_dout, a_wdata, a_rdata;
  logic          b_rrdy, b_vld, b_oob, b_ldrdy, b_cen, b_wen;
  logic [9:0]    b_saddr;
  logic [255:0]  b_dout, b_wdata, b_rdata;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   b_prev = -1;
  int   b_peak = 0;

  gsim_mem_responder #(.RD_LAT(LAT), .DEPTH(DEPTH_A)) dut_a (
    .i_clk(clk), .i_reset(i_reset),
    .i_mem_rreq(rreq_a), .i_mem_addr(addr_a), .o_mem_rrdy(a_rrdy),
    .o_mem_dout(a_dout), .o_mem_dout_vld(a_vld), .o_mem_oob(a_oob),
    .i_ld_wen(ld_wen), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_ld_done(ld_done), .o_ld_rdy(a_ldrdy),
    .o_sram_cen(a_cen), .o_sram_wen(a_wen), .o_sram_addr(a_saddr),
    .o_sram_wdata(a_wdata), .i_sram_rdata(a_rdata)
  );

  gsim_mem_responder #(.RD_LAT(LAT), .DEPTH(DEPTH_B), .MAX_OUT(1)) dut_b (
    .i_clk(clk), .i_reset(i_reset),
    .i_mem_rreq(rreq_b), .i_mem_addr(addr_b), .o_mem_rrdy(b_rrdy),
    .o_mem_dout(b_dout), .o_mem_dout_vld(b_vld), .o_mem_oob(b_oob),
    .i_ld_wen(ld_wen), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_ld_done(ld_done), .o_ld_rdy(b_ldrdy),
    .o_sram_cen(b_cen), .o_sram_wen(b_wen), .o_sram_addr(b_saddr),
    .o_sram_wdata(b_wdata), .i_sram_rdata(b_rdata)
  );

  // SRAM models with a two-cycle read latency; junk on the bus when idle
  logic [255:0] mem_a [1024];
  logic [255:0] mem_b [1024];
  logic [255:0] rq_a [2];
  logic [255:0] rq_b [2];

  always @(posedge clk) begin
    if (a_cen && a_wen) mem_a[a_saddr] <= a_wdata;
    rq_a[0] <= (a_cen && !a_wen) ? mem_a[a_saddr] : JUNK;
    rq_a[1] <= rq_a[0];
    if (b_cen && b_wen) mem_b[b_saddr] <= b_wdata;
    rq_b[0] <= (b_cen && !b_wen) ? mem_b[b_saddr] : JUNK;
    rq_b[1] <= rq_b[0];
  end
  assign a_rdata = rq_a[1];
  assign b_rdata = rq_b[1];

  function automatic logic [255:0] pat(input int i);
    logic [7:0] b;
    b = 8'(32'hA0 + i);
    return {32{b}};
  endfunction

  function automatic logic [255:0] exp_word(input logic [9:0] a, input int unsigned depth);
    if (32'(a) >= depth) return '0;
    return pat(int'(a));
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (q_a.size() != 0 || q_b.size() != 0); n++) tick();
    check("drain_a", 256'(q_a.size()), 256'(0));
    check("drain_b", 256'(q_b.size()), 256'(0));
  endtask

  // Scoreboard for instance A: push on accept, pop on each return
  always @(negedge clk) begin
    exp_t e;
    if (i_reset) begin
      q_a.delete();
    end else begin
      if (a_vld) begin
        if (q_a.size() == 0) begin
          check("a_spurious_vld", 256'(a_vld), 256'(0));
        end else begin
          e = q_a.pop_front();
          check("a_data", a_dout, e.data);
          check("a_oob", 256'(a_oob), 256'(e.oob));
          check("a_latency", 256'(cyc), 256'(e.cyc + int'(LAT) + 1));
        end
      end
      if (rreq_a && a_rrdy) begin
        e.data = exp_word(addr_a, DEPTH_A);
        e.oob  = (32'(addr_a) >= DEPTH_A);
        e.cyc  = cyc;
        q_a.push_back(e);
        check("a_acc_cen", 256'(a_cen), 256'(!e.oob));
        check("a_acc_wen", 256'(a_wen), 256'(0));
      end
    end
  end

  // Scoreboard for instance B plus accept spacing and in-flight peak
  always @(negedge clk) begin
    exp_t e;
    if (i_reset) begin
      q_b.delete();
    end else begin
      if (int'(dut_b.outstanding) > b_peak) b_peak = int'(dut_b.outstanding);
      if (b_vld) begin
        if (q_b.size() == 0) begin
          check("b_spurious_vld", 256'(b_vld), 256'(0));
        end else begin
          e = q_b.pop_front();
          check("b_data", b_dout, e.data);
          check("b_latency", 256'(cyc), 256'(e.cyc + int'(LAT) + 1));
        end
      end
      if (rreq_b && b_rrdy) begin
        if (b_prev >= 0) check("b_interval", 256'(cyc - b_prev), 256'(LAT + 1));
        b_prev = cyc;
        e.data = exp_word(addr_b, DEPTH_B);
        e.oob  = 1'b0;
        e.cyc  = cyc;
        q_b.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    repeat (3) tick();
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_rrdy", 256'(a_rrdy), 256'(0));
    check("rst_ldrdy", 256'(a_ldrdy), 256'(1));
    check("rst_vld", 256'(a_vld), 256'(0));
    check("rst_dout", a_dout, 256'(0));
    check("rst_oob", 256'(a_oob), 256'(0));
    check("rst_cen", 256'(a_cen), 256'(0));
    check("rst_state", 256'(dut_a.state), 256'(S_IDLE));

    // preload addresses 0..3 into both instances
    tick();
    for (int i = 0; i < 4; i++) begin
      ld_wen  = 1'b1;
      ld_addr = 10'(i);
      ld_data = pat(i);
      @(negedge clk);
      check("ld_rdy", 256'(a_ldrdy), 256'(1));
      if (i == 0) begin
        check("ld_cen", 256'(a_cen), 256'(1));
        check("ld_wen", 256'(a_wen), 256'(1));
        check("ld_wdata", a_wdata, pat(0));
      end else begin
        check("ld_addr", 256'(a_saddr), 256'(i));
        check("load_rrdy", 256'(a_rrdy), 256'(0));
      end
      tick();
    end
    ld_wen  = 1'b0;
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    @(negedge clk);
    check("serve_state", 256'(dut_a.state), 256'(S_SERVE));
    check("serve_rrdy_a", 256'(a_rrdy), 256'(1));
    check("serve_rrdy_b", 256'(b_rrdy), 256'(1));

    // single read
    tick();
    rreq_a = 1'b1;
    addr_a = 10'd2;
    tick();
    rreq_a = 1'b0;
    drain();

    // back-to-back reads with rreq held
    rreq_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr_a = 10'(k);
      @(negedge clk);
      check("b2b_rrdy", 256'(a_rrdy), 256'(1));
      tick();
    end
    rreq_a = 1'b0;
    drain();

    // out-of-range read
    rreq_a = 1'b1;
    addr_a = 10'd1023;
    @(negedge clk);
    check("oob_rrdy", 256'(a_rrdy), 256'(1));
    check("oob_cen", 256'(a_cen), 256'(0));
    tick();
    rreq_a = 1'b0;
    drain();

    // single read in flight, rreq held
    rreq_b = 1'b1;
    addr_b = 10'd1;
    acc = 0;
    for (int n = 0; n < 30 && acc < 4; n++) begin
      @(negedge clk);
      if (b_rrdy) acc++;
      tick();
    end
    rreq_b = 1'b0;
    check("b_accepts", 256'(acc), 256'(4));
    drain();
    check("b_peak", 256'(b_peak), 256'(1));

    // reset with two reads in flight
    rreq_a = 1'b1;
    addr_a = 10'd0;
    tick();
    addr_a = 10'd1;
    tick();
    rreq_a  = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("post_rst_vld", 256'(a_vld), 256'(0));
      tick();
    end
    @(negedge clk);
    check("post_rst_rrdy", 256'(a_rrdy), 256'(0));
    check("post_rst_ldrdy", 256'(a_ldrdy), 256'(1));
    check("post_rst_cnt", 256'(dut_a.outstanding), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
